// File: rtl/neander_uc.sv
// rtl/neander_uc.sv - Neander CPU control unit (Moore sequencer with memory wait counter)
//
// Purpose:
//    Sequences fetch, operand fetch, address fetch, execute and write-back
//    for the 8-bit Neander datapath. Strobes are decoded from the state
//    register and the wait counter. The opcode and flags come from the RI
//    and NZ registers, so they hold steady for the whole instruction.
//
// Ports:
//    clk       in   clock
//    rst       in   asynchronous active-high reset
//    opcode    in   RI[7:4]
//    flag_n    in   N flag
//    flag_z    in   Z flag
//    pc_inc    out  PC increment strobe
//    pc_load   out  PC load strobe (PC <= RDM)
//    addr_sel  out  REM source: 0 = PC, 1 = RDM
//    rem_load  out  load REM
//    rdm_src   out  RDM source: 0 = memory, 1 = AC
//    rdm_load  out  load RDM
//    ri_load   out  load RI
//    ac_load   out  load AC from ALU
//    nz_load   out  load N/Z flags
//    alu_sel   out  0 ADD, 1 AND, 2 OR, 3 NOT, 4 PASS_Y
//    mem_wr    out  memory write strobe
//    halted    out  high in HALT state

module neander_uc #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       flag_n,
   input  logic       flag_z,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       addr_sel,
   output logic       rem_load,
   output logic       rdm_src,
   output logic       rdm_load,
   output logic       ri_load,
   output logic       ac_load,
   output logic       nz_load,
   output logic [2:0] alu_sel,
   output logic       mem_wr,
   output logic       halted
);

   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_NOT = 4'h6;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JN  = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_AND  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_NOT  = 3'd3;
   localparam logic [2:0] ALU_PASS = 3'd4;

   // Terminal count of the wait counter; a read state lasts MEM_LAT cycles.
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   typedef enum logic [3:0] {
      S_INIT,
      S_F_REM,
      S_F_RD,
      S_F_RI,
      S_DEC,
      S_O_REM,
      S_O_RD,
      S_JUMP,
      S_A_REM,
      S_W_RDM,
      S_W_MEM,
      S_D_RD,
      S_EXEC,
      S_HALT
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rd_first;
   logic       rd_last;
   logic       is_jump;

   assign rd_first = (cnt_q == 4'd0);
   assign rd_last  = (cnt_q == LAT_M1);
   assign is_jump  = (opcode == OP_JMP) || (opcode == OP_JN) || (opcode == OP_JZ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      // Counter is zero outside the read states, so each read state entry
      // starts from zero; it only advances while a read is still pending.
      cnt_d    = 4'd0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      addr_sel = 1'b0;
      rem_load = 1'b0;
      rdm_src  = 1'b0;
      rdm_load = 1'b0;
      ri_load  = 1'b0;
      ac_load  = 1'b0;
      nz_load  = 1'b0;
      alu_sel  = ALU_ADD;
      mem_wr   = 1'b0;
      halted   = 1'b0;

      unique case (state_q)
         S_INIT: begin
            state_d = S_F_REM;
         end
         S_F_REM: begin
            rem_load = 1'b1;
            state_d  = S_F_RD;
         end
         S_F_RD: begin
            pc_inc   = rd_first;
            rdm_load = rd_last;
            if (rd_last) state_d = S_F_RI;
            else         cnt_d   = cnt_q + 4'd1;
         end
         S_F_RI: begin
            ri_load = 1'b1;
            state_d = S_DEC;
         end
         S_DEC: begin
            case (opcode)
               OP_NOT: begin
                  ac_load = 1'b1;
                  nz_load = 1'b1;
                  alu_sel = ALU_NOT;
                  state_d = S_F_REM;
               end
               OP_HLT: state_d = S_HALT;
               OP_JN: begin
                  // Untaken branch skips its operand byte.
                  if (flag_n) state_d = S_O_REM;
                  else begin
                     pc_inc  = 1'b1;
                     state_d = S_F_REM;
                  end
               end
               OP_JZ: begin
                  if (flag_z) state_d = S_O_REM;
                  else begin
                     pc_inc  = 1'b1;
                     state_d = S_F_REM;
                  end
               end
               OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: state_d = S_O_REM;
               default: state_d = S_F_REM;
            endcase
         end
         S_O_REM: begin
            rem_load = 1'b1;
            state_d  = S_O_RD;
         end
         S_O_RD: begin
            pc_inc   = rd_first;
            rdm_load = rd_last;
            if (rd_last) state_d = is_jump ? S_JUMP : S_A_REM;
            else         cnt_d   = cnt_q + 4'd1;
         end
         S_JUMP: begin
            pc_load = 1'b1;
            state_d = S_F_REM;
         end
         S_A_REM: begin
            addr_sel = 1'b1;
            rem_load = 1'b1;
            state_d  = (opcode == OP_STA) ? S_W_RDM : S_D_RD;
         end
         S_W_RDM: begin
            rdm_src  = 1'b1;
            rdm_load = 1'b1;
            state_d  = S_W_MEM;
         end
         S_W_MEM: begin
            mem_wr  = 1'b1;
            state_d = S_F_REM;
         end
         S_D_RD: begin
            rdm_load = rd_last;
            if (rd_last) state_d = S_EXEC;
            else         cnt_d   = cnt_q + 4'd1;
         end
         S_EXEC: begin
            ac_load = 1'b1;
            nz_load = 1'b1;
            case (opcode)
               OP_LDA:  alu_sel = ALU_PASS;
               OP_OR:   alu_sel = ALU_OR;
               OP_AND:  alu_sel = ALU_AND;
               default: alu_sel = ALU_ADD;
            endcase
            state_d = S_F_REM;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_neander_uc.sv
// tb/tb_neander_uc.sv - self-checking bench for neander_uc at memory latencies 1, 3 and 4

module tb_neander_uc;

   localparam int NI = 3;
   localparam int LATS [NI] = '{1, 3, 4};

   // Output vector layout: {pc_inc, pc_load, addr_sel, rem_load, rdm_src,
   // rdm_load, ri_load, ac_load, nz_load, alu_sel[2:0], mem_wr, halted}
   localparam logic [13:0] PI  = 14'h2000;
   localparam logic [13:0] PL  = 14'h1000;
   localparam logic [13:0] AS  = 14'h0800;
   localparam logic [13:0] RL  = 14'h0400;
   localparam logic [13:0] RS  = 14'h0200;
   localparam logic [13:0] RDL = 14'h0100;
   localparam logic [13:0] RIL = 14'h0080;
   localparam logic [13:0] ACL = 14'h0040;
   localparam logic [13:0] NZL = 14'h0020;
   localparam logic [13:0] MW  = 14'h0002;
   localparam logic [13:0] HL  = 14'h0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  opc [NI];
   logic        fn  [NI];
   logic        fz  [NI];
   logic [13:0] outv [NI];

   int checks = 0;
   int errors = 0;
   logic [13:0] exp_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic pi, pl, as, rl, rs, rdl, ril, acl, nzl, mw, h;
      logic [2:0] alu;
      neander_uc #(.MEM_LAT(LATS[g])) u_dut (
         .clk      (clk),
         .rst      (rst),
         .opcode   (opc[g]),
         .flag_n   (fn[g]),
         .flag_z   (fz[g]),
         .pc_inc   (pi),
         .pc_load  (pl),
         .addr_sel (as),
         .rem_load (rl),
         .rdm_src  (rs),
         .rdm_load (rdl),
         .ri_load  (ril),
         .ac_load  (acl),
         .nz_load  (nzl),
         .alu_sel  (alu),
         .mem_wr   (mw),
         .halted   (h)
      );
      assign outv[g] = {pi, pl, as, rl, rs, rdl, ril, acl, nzl, alu, mw, h};
   end

   function automatic logic [13:0] alu_f(int v);
      return 14'(v) << 2;
   endfunction

   task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // A memory read of L cycles: optional pc_inc on the first, rdm_load on the last.
   task automatic add_read(input int L, input bit with_inc);
      for (int j = 0; j < L; j++)
         exp_q.push_back(((with_inc && j == 0) ? PI : 14'h0) | ((j == L - 1) ? RDL : 14'h0));
   endtask

   // Expected per-cycle outputs of one instruction, starting at its F_REM cycle.
   task automatic build(input int L, input logic [3:0] op, input logic n, input logic z,
                        input int halt_cycles);
      bit lng;
      lng = 1'b0;
      exp_q.delete();
      exp_q.push_back(RL);
      add_read(L, 1'b1);
      exp_q.push_back(RIL);
      case (op)
         4'h6: exp_q.push_back(ACL | NZL | alu_f(3));
         4'hF: begin
            exp_q.push_back(14'h0);
            repeat (halt_cycles) exp_q.push_back(HL);
         end
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8: lng = 1'b1;
         4'h9: if (n) lng = 1'b1; else exp_q.push_back(PI);
         4'hA: if (z) lng = 1'b1; else exp_q.push_back(PI);
         default: exp_q.push_back(14'h0);
      endcase
      if (lng) begin
         exp_q.push_back(14'h0);
         exp_q.push_back(RL);
         add_read(L, 1'b1);
         if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
            exp_q.push_back(PL);
         end else begin
            exp_q.push_back(AS | RL);
            if (op == 4'h1) begin
               exp_q.push_back(RS | RDL);
               exp_q.push_back(MW);
            end else begin
               add_read(L, 1'b0);
               case (op)
                  4'h2:    exp_q.push_back(ACL | NZL | alu_f(4));
                  4'h4:    exp_q.push_back(ACL | NZL | alu_f(2));
                  4'h5:    exp_q.push_back(ACL | NZL | alu_f(1));
                  default: exp_q.push_back(ACL | NZL | alu_f(0));
               endcase
            end
         end
      end
   endtask

   // Runs one instruction on instance k; ncyc < 0 checks the whole trace.
   task automatic run(input int k, input logic [3:0] op, input logic n, input logic z,
                      input int ncyc, input int halt_cycles, input string tag);
      int limit;
      build(LATS[k], op, n, z, halt_cycles);
      limit = (ncyc < 0) ? exp_q.size() : ncyc;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            opc[k] = op;
            fn[k]  = n;
            fz[k]  = z;
         end
         chk($sformatf("%s k%0d op%h cyc%0d", tag, k, op, i), outv[k], exp_q[i]);
      end
   endtask

   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) chk($sformatf("%s async k%0d", tag, k), outv[k], 14'h0);
      for (int k = 0; k < NI; k++) begin
         opc[k] = 4'h0;
         fn[k]  = 1'b0;
         fz[k]  = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) chk($sformatf("%s init k%0d", tag, k), outv[k], 14'h0);
   endtask

   task automatic run_random(input int k, input int count);
      logic [3:0] op;
      logic n, z;
      for (int i = 0; i < count; i++) begin
         op = 4'($urandom_range(0, 14));
         n  = 1'($urandom_range(0, 1));
         z  = 1'($urandom_range(0, 1));
         run(k, op, n, z, -1, 0, "rand");
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         opc[k] = 4'h0;
         fn[k]  = 1'b0;
         fz[k]  = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) chk($sformatf("reset k%0d", k), outv[k], 14'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) chk($sformatf("init k%0d", k), outv[k], 14'h0);

      // Latency 1: every opcode class, both branch outcomes.
      run(0, 4'h0, 1'b0, 1'b0, -1, 0, "nop");
      run(0, 4'h0, 1'b0, 1'b0, -1, 0, "nop");
      run(0, 4'h0, 1'b0, 1'b0, -1, 0, "nop");
      run(0, 4'h2, 1'b0, 1'b0, -1, 0, "lda");
      run(0, 4'h6, 1'b0, 1'b0, -1, 0, "not");
      run(0, 4'h9, 1'b0, 1'b1, -1, 0, "jn_untaken");
      run(0, 4'h9, 1'b1, 1'b0, -1, 0, "jn_taken");
      run(0, 4'hA, 1'b1, 1'b0, -1, 0, "jz_untaken");
      run(0, 4'hA, 1'b0, 1'b1, -1, 0, "jz_taken");
      run(0, 4'h8, 1'b0, 1'b0, -1, 0, "jmp");
      run(0, 4'h3, 1'b0, 1'b0, -1, 0, "add");
      run(0, 4'h4, 1'b0, 1'b0, -1, 0, "or");
      run(0, 4'h5, 1'b0, 1'b0, -1, 0, "and");
      run(0, 4'h1, 1'b0, 1'b0, -1, 0, "sta");
      run(0, 4'h7, 1'b0, 1'b0, -1, 0, "unused7");
      run(0, 4'hC, 1'b0, 1'b0, -1, 0, "unusedC");
      run_random(0, 25);

      // Latency 3.
      async_reset("to_k1");
      run(1, 4'h1, 1'b0, 1'b0, -1, 0, "sta3");
      run_random(1, 25);

      // Latency 4.
      async_reset("to_k2");
      run_random(2, 25);

      // Halt holds until reset, then fetch restarts.
      async_reset("to_halt");
      run(0, 4'hF, 1'b0, 1'b0, -1, 22, "hlt");
      async_reset("from_halt");
      run(0, 4'h0, 1'b0, 1'b0, -1, 0, "after_halt");

      // Reset in the middle of an operand read wait at latency 4.
      async_reset("to_mid");
      run(2, 4'h2, 1'b0, 1'b0, 10, 0, "lda_partial");
      async_reset("mid_ord");
      run(2, 4'h0, 1'b0, 1'b0, -1, 0, "after_mid");
      run(2, 4'h1, 1'b0, 1'b0, -1, 0, "sta4");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
